// File: rtl/div_ratio_pkg.sv
// Shared definitions for the divider ratio feeder: state encoding, octant
// bit positions and the ratio saturation constant.
package div_ratio_pkg;

    typedef logic [1:0] state_t;

    // Plain constants rather than an enum so that older tools can still read them.
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t WAIT = 2'd2;
    localparam state_t HOLD = 2'd3;

    localparam int OCT_SIGN_I = 2;
    localparam int OCT_SIGN_Q = 1;
    localparam int OCT_SWAP   = 0;

    // Ratio of 1.0 in Q1.frac_bits, which is also the largest legal ratio.
    function automatic int unsigned ratio_sat(input int unsigned frac_bits);
        return 32'd1 << frac_bits;
    endfunction

endpackage

// File: rtl/div_ratio_feeder_sat_abs.sv
// Combinational saturating absolute value: the most negative input maps to
// the largest positive magnitude so the result always fits in WIDTH-1 bits.
module sat_abs #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-2:0] mag
);

    logic [WIDTH-2:0] neg_low;

    assign neg_low = ~x[WIDTH-2:0] + (WIDTH-1)'(1);

    always_comb begin
        mag = x[WIDTH-2:0];
        if (x[WIDTH-1]) begin
            if (x[WIDTH-2:0] == '0) begin
                mag = '1;
            end else begin
                mag = neg_low;
            end
        end
    end

endmodule

// File: rtl/div_ratio_feeder.sv
// Folds I/Q into the first octant, drives the multi-cycle divider and hands a
// Q1.FRAC_BITS ratio plus octant code downstream. Define DIV_RATIO_ROUND_EN
// for round-to-nearest; otherwise the quotient is truncated.
module div_ratio_feeder
    import div_ratio_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16,
    parameter int FRAC_BITS      = 15,
    parameter int DIV_LATENCY    = 34
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SAMPLE_WIDTH-1:0]   in_i,
    input  logic [SAMPLE_WIDTH-1:0]   in_q,
    output logic                      div_start,
    output logic [DIVIDEND_WIDTH-1:0] div_dividend,
    output logic [DIVISOR_WIDTH-1:0]  div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]  div_remainder,
    input  logic                      div_overflow,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAC_BITS:0]        out_ratio,
    output logic [2:0]                out_octant,
    output logic                      out_zero
);

    localparam int MAG_W = SAMPLE_WIDTH - 1;
    localparam int CNT_W = $clog2(DIV_LATENCY + 1);
    localparam logic [DIVIDEND_WIDTH:0] SAT_Q = (DIVIDEND_WIDTH + 1)'(ratio_sat(FRAC_BITS));

    logic [SAMPLE_WIDTH-1:0] samp [2];
    logic [MAG_W-1:0]        mag  [2];

    assign samp[0] = in_i;
    assign samp[1] = in_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            sat_abs #(.WIDTH(SAMPLE_WIDTH)) u_sat_abs (
                .x   (samp[gi]),
                .mag (mag[gi])
            );
        end
    endgenerate

    logic             swap;
    logic [MAG_W-1:0] min_mag;
    logic [MAG_W-1:0] max_mag;

    assign swap    = mag[1] > mag[0];
    assign min_mag = swap ? mag[0] : mag[1];
    assign max_mag = swap ? mag[1] : mag[0];

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          counter_q, counter_d;
    logic                      in_ready_q, in_ready_d;
    logic                      div_start_q, div_start_d;
    logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d;
    logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
    logic                      out_valid_q, out_valid_d;
    logic [FRAC_BITS:0]        out_ratio_q, out_ratio_d;
    logic [2:0]                out_octant_q, out_octant_d;
    logic                      out_zero_q, out_zero_d;

    // One extra bit so a rounded all-ones quotient cannot wrap before saturation.
    logic [DIVIDEND_WIDTH:0] q_ext;
    logic [FRAC_BITS:0]      ratio_cap;

`ifdef DIV_RATIO_ROUND_EN
    logic [DIVISOR_WIDTH:0] rem_x2;
    logic                   round_up;

    assign rem_x2   = {div_remainder, 1'b0};
    assign round_up = rem_x2 >= {1'b0, divisor_q};
    assign q_ext    = {1'b0, div_quotient} + (DIVIDEND_WIDTH + 1)'(round_up);
`else
    logic unused_rem;

    assign unused_rem = ^div_remainder;
    assign q_ext      = {1'b0, div_quotient};
`endif

    assign ratio_cap = (div_overflow || (q_ext > SAT_Q)) ? SAT_Q[FRAC_BITS:0] : q_ext[FRAC_BITS:0];

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        in_ready_d   = in_ready_q;
        div_start_d  = 1'b0;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        out_valid_d  = out_valid_q;
        out_ratio_d  = out_ratio_q;
        out_octant_d = out_octant_q;
        out_zero_d   = out_zero_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    state_d                  = LOAD;
                    in_ready_d               = 1'b0;
                    dividend_d               = DIVIDEND_WIDTH'(min_mag) << FRAC_BITS;
                    divisor_d                = DIVISOR_WIDTH'(max_mag);
                    div_start_d              = (max_mag != '0);
                    out_octant_d[OCT_SIGN_I] = in_i[SAMPLE_WIDTH-1];
                    out_octant_d[OCT_SIGN_Q] = in_q[SAMPLE_WIDTH-1];
                    out_octant_d[OCT_SWAP]   = swap;
                end
            end
            LOAD: begin
                if (divisor_q == '0) begin
                    state_d     = HOLD;
                    out_ratio_d = '0;
                    out_zero_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    state_d   = WAIT;
                    counter_d = '0;
                end
            end
            WAIT: begin
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(DIV_LATENCY - 1)) begin
                    state_d     = HOLD;
                    out_ratio_d = ratio_cap;
                    out_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            in_ready_q   <= 1'b0;
            div_start_q  <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ratio_q  <= '0;
            out_octant_q <= '0;
            out_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            in_ready_q   <= in_ready_d;
            div_start_q  <= div_start_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            out_valid_q  <= out_valid_d;
            out_ratio_q  <= out_ratio_d;
            out_octant_q <= out_octant_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign div_start    = div_start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign out_valid    = out_valid_q;
    assign out_ratio    = out_ratio_q;
    assign out_octant   = out_octant_q;
    assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_div_ratio_feeder.sv
// Directed bench for div_ratio_feeder with a behavioural fixed-latency divider
// that drives a poison quotient until its result is due.
module tb_div_ratio_feeder;

    localparam int SW  = 16;
    localparam int DDW = 32;
    localparam int DVW = 16;
    localparam int FB  = 15;
    localparam int LAT = 34;

`ifdef DIV_RATIO_ROUND_EN
    localparam int EXP_R_300_900 = 10923;
`else
    localparam int EXP_R_300_900 = 10922;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [SW-1:0]  in_i = '0;
    logic [SW-1:0]  in_q = '0;
    logic           div_start;
    logic [DDW-1:0] div_dividend;
    logic [DVW-1:0] div_divisor;
    logic [DDW-1:0] div_quotient;
    logic [DVW-1:0] div_remainder;
    logic           div_overflow;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [FB:0]    out_ratio;
    logic [2:0]     out_octant;
    logic           out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_ratio_feeder #(
        .SAMPLE_WIDTH   (SW),
        .DIVIDEND_WIDTH (DDW),
        .DIVISOR_WIDTH  (DVW),
        .FRAC_BITS      (FB),
        .DIV_LATENCY    (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_i          (in_i),
        .in_q          (in_q),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_overflow  (div_overflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ratio     (out_ratio),
        .out_octant    (out_octant),
        .out_zero      (out_zero)
    );

    // Divider model: latches operands on start; the result is valid from the
    // cycle LAT after the start cycle and poisoned before that.
    logic [DDW-1:0] m_dd = '0;
    logic [DVW-1:0] m_dv = '0;
    int             m_k  = 1000;

    always @(posedge clk) begin
        if (div_start) begin
            m_dd <= div_dividend;
            m_dv <= div_divisor;
            m_k  <= 1;
        end else if (m_k < 1000) begin
            m_k <= m_k + 1;
        end
    end

    always_comb begin
        div_quotient  = 32'hDEAD_BEEF;
        div_remainder = 16'hFFFF;
        div_overflow  = 1'b0;
        if (m_k >= LAT && m_dv != '0) begin
            div_quotient  = m_dd / DDW'(m_dv);
            div_remainder = DVW'(m_dd % DDW'(m_dv));
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One transaction: accept, wait for the result, optionally stall HOLD
    // while a competing sample is offered, then complete the handshake.
    task automatic run_sample(input logic [SW-1:0] si, input logic [SW-1:0] sq,
                              input int exp_ratio, input int exp_oct, input int exp_zero,
                              input int exp_lat, input int exp_starts,
                              input longint exp_dd, input longint exp_dv,
                              input int hold_cyc, input logic [SW-1:0] bi, input logic [SW-1:0] bq);
        int edges;
        int starts;
        int bad;
        int t;
        check_eq("in_ready_pre", in_ready, 1);
        in_i     = si;
        in_q     = sq;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges  = 1;
        starts = 0;
        t      = 0;
        check_eq("in_ready_drop", in_ready, 0);
        while (!out_valid && t < 200) begin
            if (div_start) begin
                starts++;
                check_eq("dividend", div_dividend, exp_dd);
                check_eq("divisor", div_divisor, exp_dv);
            end
            @(posedge clk); #1;
            edges++;
            t++;
        end
        check_eq("out_valid", out_valid, 1);
        check_eq("latency_edges", edges, exp_lat);
        check_eq("start_pulses", starts, exp_starts);
        check_eq("ratio", out_ratio, exp_ratio);
        check_eq("octant", out_octant, exp_oct);
        check_eq("zero", out_zero, exp_zero);
        $display("[TB] I=%0d Q=%0d ratio=%0d octant=%03b zero=%0d edges=%0d",
                 $signed(si), $signed(sq), out_ratio, out_octant, out_zero, edges);
        if (hold_cyc > 0) begin
            bad      = 0;
            in_i     = bi;
            in_q     = bq;
            in_valid = 1'b1;
            for (int c = 0; c < hold_cyc; c++) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || div_start || out_ratio != exp_ratio
                    || out_octant != exp_oct || out_zero != exp_zero) begin
                    bad++;
                end
            end
            check_eq("hold_stable_bad_cycles", bad, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("valid_drop", out_valid, 0);
        check_eq("in_ready_rise", in_ready, 1);
    endtask

    initial begin
        int seen;
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_div_start", div_start, 0);
        check_eq("rst_ratio", out_ratio, 0);
        check_eq("rst_divisor", div_divisor, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("in_ready_after_rst", in_ready, 1);

        run_sample(16'sd1000, 16'sd500, 16384, 3'b000, 0, LAT + 2, 1, 16384000, 1000, 0, '0, '0);
        run_sample(-16'sd300, 16'sd900, EXP_R_300_900, 3'b101, 0, LAT + 2, 1, 9830400, 900, 0, '0, '0);
        run_sample(16'sd0, 16'sd0, 0, 3'b000, 1, 2, 0, 0, 0, 0, '0, '0);
        run_sample(16'h8000, 16'h8000, 32768, 3'b110, 0, LAT + 2, 1, 1073709056, 32767, 0, '0, '0);

        // Stall HOLD for 20 cycles with a second sample waiting; it must be
        // taken only after the handshake.
        run_sample(16'sd1000, 16'sd500, 16384, 3'b000, 0, LAT + 2, 1, 16384000, 1000, 20, -16'sd300, 16'sd900);
        run_sample(-16'sd300, 16'sd900, EXP_R_300_900, 3'b101, 0, LAT + 2, 1, 9830400, 900, 0, '0, '0);

        // Reset in the middle of WAIT.
        in_i     = -16'sd1000;
        in_q     = 16'sd500;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_in_ready", in_ready, 0);
        check_eq("async_rst_ratio", out_ratio, 0);
        check_eq("async_rst_octant", out_octant, 0);
        check_eq("async_rst_dividend", div_dividend, 0);
        check_eq("async_rst_divisor", div_divisor, 0);
        $display("[TB] reset asserted mid-WAIT");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("no_valid_after_abort", seen, 0);
        run_sample(16'sd200, 16'sd100, 16384, 3'b000, 0, LAT + 2, 1, 3276800, 200, 0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
